// File: rtl/tns_dec_seq.sv
// tns_dec_seq: sequential 3C1S TNS decoder, one 3-bit group per clock, weights from WTAB.
// Optional overflow flag: define TNS_DEC_OVF_EN to build the carry detection behind err.

`ifndef BLEN05
`define BLEN05 16
`endif

// Fallback NGRP=5 weight set, used when TNS.vh has not been included ahead of this file.
`ifndef TNS05_A
`define TNS01_C 16'd1
`define TNS01_B 16'd2
`define TNS01_A 16'd4
`define TNS02_C 16'd7
`define TNS02_B 16'd14
`define TNS02_A 16'd28
`define TNS03_C 16'd49
`define TNS03_B 16'd98
`define TNS03_A 16'd196
`define TNS04_C 16'd343
`define TNS04_B 16'd686
`define TNS04_A 16'd1372
`define TNS05_C 16'd2401
`define TNS05_B 16'd4802
`define TNS05_A 16'd9604
`endif

module tns_dec_seq #(
  parameter int NGRP = 5,
  parameter int BLEN = `BLEN05,
  parameter logic [3*NGRP*BLEN-1:0] WTAB = {
    `TNS05_A, `TNS05_B, `TNS05_C,
    `TNS04_A, `TNS04_B, `TNS04_C,
    `TNS03_A, `TNS03_B, `TNS03_C,
    `TNS02_A, `TNS02_B, `TNS02_C,
    `TNS01_A, `TNS01_B, `TNS01_C
  }
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*NGRP-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLEN-1:0]   dataout,
  output logic              busy,
  output logic              err
);

  localparam int CW = (NGRP > 1) ? $clog2(NGRP) : 1;
`ifdef TNS_DEC_OVF_EN
  localparam int PW = BLEN + 2;
`else
  localparam int PW = BLEN;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [3*NGRP-1:0] code_reg;
  logic [BLEN-1:0]   acc_reg, acc_next;
  logic [CW-1:0]     cnt_reg;
  logic [PW-1:0]     psum [NGRP];
  logic [PW-1:0]     psum_sel;
  logic              last_grp;

  // Every group's partial sum is formed in parallel; cnt_reg picks the one to add.
  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam logic [BLEN-1:0] W0 = WTAB[(3*gi)*BLEN +: BLEN];
      localparam logic [BLEN-1:0] W1 = WTAB[(3*gi+1)*BLEN +: BLEN];
      localparam logic [BLEN-1:0] W2 = WTAB[(3*gi+2)*BLEN +: BLEN];
      logic [2:0] g;
      assign g = code_reg[3*gi +: 3];
      assign psum[gi] = (g[0] ? PW'(W0) : '0)
                      + (g[1] ? PW'(W1) : '0)
                      + (g[2] ? PW'(W2) : '0);
    end
  endgenerate

  always_comb begin
    psum_sel = '0;
    for (int i = 0; i < NGRP; i++) begin
      if (cnt_reg == CW'(i)) psum_sel = psum[i];
    end
  end

  assign last_grp = (cnt_reg == '0);

`ifdef TNS_DEC_OVF_EN
  logic [BLEN+2:0] acc_full;
  logic            err_reg;

  assign acc_full = (BLEN+3)'(acc_reg) + (BLEN+3)'(psum_sel);
  assign acc_next = acc_full[BLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      err_reg <= 1'b0;
    end else if (state_reg == ACC && (|acc_full[BLEN+2:BLEN])) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign acc_next = acc_reg + psum_sel;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = ACC;
      ACC:     if (last_grp)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE:    in_ready = !rst;
      ACC:     busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Groups are consumed MSB first, so cnt starts at NGRP-1 and counts down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_reg <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          code_reg <= codein;
          acc_reg  <= '0;
          cnt_reg  <= CW'(NGRP - 1);
        end
        ACC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign dataout = acc_reg;

endmodule

// File: tb/tb_tns_dec_seq.sv
// tb_tns_dec_seq: checks tns_dec_seq against a weighted-bit-sum model, with and without TNS_DEC_OVF_EN.
module tb_tns_dec_seq;

`ifdef TNS_DEC_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned wt [3][15];

  // Instance A: NGRP=2, BLEN=8, weights 1,2,3,5,8,13.
  logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_err;
  logic [5:0] a_codein;
  logic [7:0] a_dataout;
  tns_dec_seq #(.NGRP(2), .BLEN(8), .WTAB({8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1})) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .codein(a_codein),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .dataout(a_dataout), .busy(a_busy), .err(a_err));

  // Instance O: overflow weights 100,100,100,1,1,1.
  logic       o_rst, o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_busy, o_err;
  logic [5:0] o_codein;
  logic [7:0] o_dataout;
  tns_dec_seq #(.NGRP(2), .BLEN(8), .WTAB({8'd1, 8'd1, 8'd1, 8'd100, 8'd100, 8'd100})) dut_o (
    .clk(clk), .rst(o_rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .codein(o_codein),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .dataout(o_dataout), .busy(o_busy), .err(o_err));

  // Instance D: default parameters.
  logic        d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy, d_err;
  logic [14:0] d_codein;
  logic [15:0] d_dataout;
  tns_dec_seq dut_d (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .codein(d_codein),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .dataout(d_dataout), .busy(d_busy), .err(d_err));

  function automatic longint unsigned model_sum(input int sel, input logic [14:0] code, input int nbits);
    longint unsigned s = 0;
    for (int k = 0; k < nbits; k++) begin
      if (code[k]) s += longint'(wt[sel][k]);
    end
    return s;
  endfunction

  task automatic init_tables();
    int unsigned wa [6] = '{1, 2, 3, 5, 8, 13};
    int unsigned wo [6] = '{100, 100, 100, 1, 1, 1};
    for (int k = 0; k < 15; k++) begin
      int unsigned b = 1;
      for (int j = 0; j < k / 3; j++) b = b * 7;
      wt[0][k] = (k < 6) ? wa[k] : 0;
      wt[1][k] = (k < 6) ? wo[k] : 0;
      wt[2][k] = (32'd1 << (k % 3)) * b;
    end
  endtask

  task automatic a_run(input logic [5:0] code, input int hold, input bit pulse, input string name);
    longint unsigned s;
    int edges;
    logic [7:0] exp_d;
    logic exp_e;
    s = model_sum(0, 15'(code), 6);
    exp_d = 8'(s % 256);
    exp_e = OVF && (s >= 256);
    a_out_ready = (hold == 0);
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL %s idle_in_ready got=%b want=1", name, a_in_ready); end
    a_codein = code;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    edges = 1;
    while (a_out_valid !== 1'b1 && edges < 20) begin
      checks++;
      if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
        errors++; $display("FAIL %s busy_flags in_ready=%b busy=%b want 0/1", name, a_in_ready, a_busy);
      end
      a_in_valid = pulse;
      a_codein = 6'($urandom);
      @(negedge clk);
      edges++;
    end
    a_in_valid = 1'b0;
    checks++;
    if (edges !== 3) begin errors++; $display("FAIL %s latency got=%0d edges want=3", name, edges); end
    checks++;
    if (a_dataout !== exp_d) begin errors++; $display("FAIL %s dataout got=%0d want=%0d", name, a_dataout, exp_d); end
    checks++;
    if (a_err !== exp_e) begin errors++; $display("FAIL %s err got=%b want=%b", name, a_err, exp_e); end
    checks++;
    if (a_in_ready !== 1'b0) begin errors++; $display("FAIL %s done_in_ready got=%b want=0", name, a_in_ready); end
    for (int i = 0; i < hold; i++) begin
      a_codein = 6'($urandom);
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_dataout !== exp_d || a_err !== exp_e) begin
        errors++;
        $display("FAIL %s hold_%0d out_valid=%b dataout=%0d err=%b want 1/%0d/%b", name, i, a_out_valid, a_dataout, a_err, exp_d, exp_e);
      end
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release out_valid=%b in_ready=%b busy=%b want 0/1/0", name, a_out_valid, a_in_ready, a_busy);
    end
  endtask

  task automatic o_run(input logic [5:0] code, input string name);
    longint unsigned s;
    int edges;
    logic [7:0] exp_d;
    logic exp_e;
    s = model_sum(1, 15'(code), 6);
    exp_d = 8'(s % 256);
    exp_e = OVF && (s >= 256);
    o_out_ready = 1'b1;
    @(negedge clk);
    o_codein = code;
    o_in_valid = 1'b1;
    @(negedge clk);
    o_in_valid = 1'b0;
    edges = 1;
    while (o_out_valid !== 1'b1 && edges < 20) begin @(negedge clk); edges++; end
    checks++;
    if (edges !== 3) begin errors++; $display("FAIL %s latency got=%0d edges want=3", name, edges); end
    checks++;
    if (o_dataout !== exp_d) begin errors++; $display("FAIL %s dataout got=%0d want=%0d", name, o_dataout, exp_d); end
    checks++;
    if (o_err !== exp_e) begin errors++; $display("FAIL %s err got=%b want=%b", name, o_err, exp_e); end
    @(negedge clk);
  endtask

  task automatic d_run(input logic [14:0] code, input int hold, input int idx);
    longint unsigned s;
    int edges;
    logic [15:0] exp_d;
    logic exp_e;
    s = model_sum(2, code, 15);
    exp_d = 16'(s % 65536);
    exp_e = OVF && (s >= 65536);
    d_out_ready = (hold == 0);
    @(negedge clk);
    d_codein = code;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    d_codein = 15'($urandom);
    edges = 1;
    while (d_out_valid !== 1'b1 && edges < 40) begin @(negedge clk); edges++; end
    checks++;
    if (edges !== 6) begin errors++; $display("FAIL rand_%0d latency got=%0d edges want=6", idx, edges); end
    checks++;
    if (d_dataout !== exp_d) begin errors++; $display("FAIL rand_%0d dataout code=%h got=%0d want=%0d", idx, code, d_dataout, exp_d); end
    checks++;
    if (d_err !== exp_e) begin errors++; $display("FAIL rand_%0d err got=%b want=%b", idx, d_err, exp_e); end
    repeat (hold) @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b1 || d_dataout !== exp_d) begin
      errors++; $display("FAIL rand_%0d held out_valid=%b dataout=%0d want 1/%0d", idx, d_out_valid, d_dataout, exp_d);
    end
    d_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d_out_valid !== 1'b0) begin errors++; $display("FAIL rand_%0d release out_valid=%b want=0", idx, d_out_valid); end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; o_rst = 1'b1; d_rst = 1'b1;
    a_in_valid = 1'b0; o_in_valid = 1'b0; d_in_valid = 1'b0;
    a_out_ready = 1'b1; o_out_ready = 1'b1; d_out_ready = 1'b1;
    a_codein = '0; o_codein = '0; d_codein = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_dataout !== 8'd0 || a_busy !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b dataout=%0d busy=%b err=%b want all 0",
               a_in_ready, a_out_valid, a_dataout, a_busy, a_err);
    end
    a_rst = 1'b0; o_rst = 1'b0; d_rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready got=%b want=1", a_in_ready); end
    checks++;
    if (d_in_ready !== 1'b1 || d_dataout !== 16'd0) begin
      errors++; $display("FAIL reset_default in_ready=%b dataout=%0d want 1/0", d_in_ready, d_dataout);
    end
  endtask

  task automatic test_basic();
    a_run(6'b101001, 0, 1'b0, "basic");
  endtask

  task automatic test_ones_zeros();
    a_run(6'b111111, 0, 1'b1, "all_ones");
    a_run(6'b000000, 0, 1'b1, "all_zeros");
  endtask

  task automatic test_backpressure();
    a_run(6'b101001, 10, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    a_codein = 6'b111111;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_rst = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid in_ready_during_rst got=%b want=0", a_in_ready); end
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_dataout !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid after in_ready=%b busy=%b out_valid=%b dataout=%0d want 1/0/0/0",
               a_in_ready, a_busy, a_out_valid, a_dataout);
    end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (a_out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid aborted word produced out_valid got=1 want=0"); end
    a_run(6'b000011, 0, 1'b0, "after_reset");
  endtask

  task automatic test_rst_and_valid();
    bit seen;
    @(negedge clk);
    a_rst = 1'b1;
    a_in_valid = 1'b1;
    a_codein = 6'b111111;
    @(negedge clk);
    a_rst = 1'b0;
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_and_valid busy=%b in_ready=%b want 0/1", a_busy, a_in_ready);
    end
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (a_out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_and_valid out_valid rose got=1 want=0"); end
  endtask

  task automatic test_overflow();
    o_run(6'b000111, "overflow");
    o_run(6'b000001, "post_overflow");
  endtask

  task automatic test_default_random();
    for (int i = 0; i < 200; i++) begin
      d_run(15'($urandom), int'($urandom_range(0, 2)), i);
    end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_basic();
    test_ones_zeros();
    test_backpressure();
    test_reset_mid();
    test_rst_and_valid();
    test_overflow();
    test_default_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
